ex_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the EX stage.
- Accepts one op from EX and asserts BUSY so hazard logic stalls IF/ID/EX.
- Iterates a shift-add multiplier or a restoring divider for XLEN cycles, then returns RESULT with a one-cycle DONE pulse.
- The single-cycle ALU keeps the RV32I ops only.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 47 ++++
 rtl/ex_muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// op codes (same encoding as the ALU SELECT field), FSM states,
// the divide-by-zero quotient and op classification helpers.
package muldiv_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    // Wide enough for any XLEN up to 64; users slice the low XLEN bits.
    localparam logic [63:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    // rs1 is treated as two's complement.
    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement.
    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Divide family (DIV/DIVU/REM/REMU).
    function automatic logic is_div(input logic [4:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath.
// Multiply: {accHi, accLo} is the product/multiplier pair; add opnd
// (multiplicand) into the high half when the multiplier LSB is set,
// then shift the whole pair right by one.
// Divide: accHi is the remainder, accLo the dividend/quotient; shift
// in the next dividend bit, trial-subtract opnd (divisor) on an
// XLEN+1-bit partial remainder and restore on borrow.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            isDiv,
    input  logic [XLEN-1:0] accHi,
    input  logic [XLEN-1:0] accLo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] nextHi,
    output logic [XLEN-1:0] nextLo
);

    logic [XLEN:0] mulSum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    assign shifted = {accHi, accLo[XLEN-1]};
    assign trial   = shifted - {1'b0, opnd};

    // Pick the shift-add or the restoring-divide update.
    always_comb begin
        nextHi = '0;
        nextLo = '0;
        if (isDiv) begin
            if (!trial[XLEN]) begin
                nextHi = trial[XLEN-1:0];
                nextLo = {accLo[XLEN-2:0], 1'b1};
            end else begin
                nextHi = shifted[XLEN-1:0];
                nextLo = {accLo[XLEN-2:0], 1'b0};
            end
        end else begin
            nextHi = mulSum[XLEN:1];
            nextLo = {mulSum[0], accLo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M sequencer for the EX stage. Takes one op, holds
// BUSY so the front end stalls, iterates XLEN shift-add or restoring
// divide steps, then presents RESULT with a one-cycle DONE pulse.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies form the full
// product in PREP with a combinational multiplier and skip CALC.
module ex_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t           state;
    logic [CNT_W-1:0]        cnt;
    logic [4:0]              opReg;
    logic signed [XLEN-1:0]  aReg;
    logic signed [XLEN-1:0]  bReg;
    logic                    negReg;
    logic [XLEN-1:0]         opnd;
    logic [XLEN-1:0]         accHi;
    logic [XLEN-1:0]         accLo;

    logic                    isDivOp;
    logic                    isRem;
    logic                    signA;
    logic                    signB;
    logic [XLEN-1:0]         magA;
    logic [XLEN-1:0]         magB;
    logic                    negNext;
    logic                    divZero;
    logic                    divOvf;
    logic [XLEN-1:0]         specialRes;
    logic [XLEN-1:0]         stepHi;
    logic [XLEN-1:0]         stepLo;
    logic [2*XLEN-1:0]       prodFix;
    logic [XLEN-1:0]         quoFix;
    logic [XLEN-1:0]         remFix;
    logic [XLEN-1:0]         fixRes;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]       fastProd;
`endif

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] negateWide(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    // Operand classification and magnitudes, evaluated on the latched op in PREP.
    assign isDivOp = is_div(opReg);
    assign isRem   = isDivOp & opReg[1];
    assign signA   = is_signed_a(opReg) && (aReg < 0);
    assign signB   = is_signed_b(opReg) && (bReg < 0);
    assign magA    = signA ? negate(aReg) : aReg;
    assign magB    = signB ? negate(bReg) : bReg;
    // Remainder follows the dividend; quotient and product follow both.
    assign negNext = isRem ? signA : (signA ^ signB);

    assign divZero = isDivOp && (bReg == '0);
    assign divOvf  = ((opReg == OP_DIV) || (opReg == OP_REM)) &&
                     (aReg == MIN_NEG) && (bReg == '1);
    assign specialRes = divZero ? (isRem ? aReg : DIV_BY_ZERO_Q[XLEN-1:0])
                                : (isRem ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
    assign fastProd = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
`endif

    muldiv_step #(.XLEN(XLEN)) uStep (
        .isDiv  (isDivOp),
        .accHi  (accHi),
        .accLo  (accLo),
        .opnd   (opnd),
        .nextHi (stepHi),
        .nextLo (stepLo)
    );

    assign prodFix = negReg ? negateWide({accHi, accLo}) : {accHi, accLo};
    assign quoFix  = negReg ? negate(accLo) : accLo;
    assign remFix  = negReg ? negate(accHi) : accHi;

    // Sign-corrected output selection used in FIX.
    always_comb begin
        fixRes = '0;
        case (opReg)
            OP_MUL:                       fixRes = prodFix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodFix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fixRes = quoFix;
            OP_REM, OP_REMU:              fixRes = remFix;
            default:                      fixRes = '0;
        endcase
    end

    // Sequencer FSM with registered BUSY/DONE/RESULT; reset beats flush.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            opReg  <= '0;
            aReg   <= '0;
            bReg   <= '0;
            negReg <= 1'b0;
            opnd   <= '0;
            accHi  <= '0;
            accLo  <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
        end else if (FLUSH) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START && (SELECT[4:3] == 2'b01)) begin
                        opReg <= SELECT;
                        aReg  <= DATA1;
                        bReg  <= DATA2;
                        BUSY  <= 1'b1;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    negReg <= negNext;
                    if (divZero || divOvf) begin
                        RESULT <= specialRes;
                        DONE   <= 1'b1;
                        state  <= ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!isDivOp) begin
                        accHi <= fastProd[2*XLEN-1:XLEN];
                        accLo <= fastProd[XLEN-1:0];
                        state <= ST_FIX;
`endif
                    end else begin
                        accHi <= '0;
                        accLo <= isDivOp ? magA : magB;
                        opnd  <= isDivOp ? magB : magA;
                        cnt   <= CNT_INIT;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    RESULT <= fixRes;
                    DONE   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: hand-computed RV32M results,
// latencies counted from the START edge, flush/reset/ignore behaviour.
module tb_ex_muldiv_seq;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 35;
`endif
    localparam int DIV_LAT = 35;
    localparam int SPC_LAT = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [4:0]  SELECT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        FLUSH;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] lastRes = 32'h0;

    ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op from an IDLE negedge, find DONE, check latency/result,
    // then confirm DONE was a single-cycle pulse.
    task automatic runOp(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int expLat, input string tag);
        int lat;
        bit seen;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        seen  = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge CLK);
            lat = i;
            if (DONE === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(expLat));
        chk({tag, "_result"}, RESULT, exp);
        chk({tag, "_busy_at_done"}, 32'(BUSY), 32'd1);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        chk({tag, "_busy_after"}, 32'(BUSY), 32'd0);
        lastRes = exp;
    endtask

    initial begin
        bit sawDone;
        bit sawBusy;

        RESET  = 1'b0;
        START  = 1'b0;
        FLUSH  = 1'b0;
        SELECT = 5'b0;
        DATA1  = 32'h0;
        DATA2  = 32'h0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_result", RESULT, 32'h0);
        RESET = 1'b1;
        @(negedge CLK);

        // Multiply family.
        runOp(OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3");
        runOp(OP_MULH,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT, "mulh_7_m3");
        runOp(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max");
        runOp(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1_2");
        runOp(OP_MULHU,  32'h0001_0000, 32'h0003_0000, 32'h0000_0003, MUL_LAT, "mulhu_shift");

        // Divide family.
        runOp(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_m7_2");
        runOp(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem_m7_2");
        runOp(OP_DIVU, 32'd100,       32'd7, 32'd14,        DIV_LAT, "divu_100_7");
        runOp(OP_REMU, 32'd100,       32'd7, 32'd2,         DIV_LAT, "remu_100_7");
        runOp(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2");
        runOp(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1,         DIV_LAT, "rem_7_m2");

        // Special cases finish from PREP.
        runOp(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, "div_5_0");
        runOp(OP_REMU, 32'd5, 32'd0, 32'd5,         SPC_LAT, "remu_5_0");
        runOp(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "div_ovf");
        runOp(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SPC_LAT, "rem_ovf");
        runOp(OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_prior");

        // Ignored START while busy, then flush mid-divide.
        sawDone = 1'b0;
        SELECT = OP_DIVU;
        DATA1  = 32'd100;
        DATA2  = 32'd7;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CLK);
            if (DONE === 1'b1) sawDone = 1'b1;
            if (cyc == 10) begin
                SELECT = OP_MUL;
                DATA1  = 32'd3;
                DATA2  = 32'd3;
                START  = 1'b1;
            end
            if (cyc == 11) begin
                START = 1'b0;
                chk("flush_busy_during_ignored_start", 32'(BUSY), 32'd1);
            end
            if (cyc == 20) FLUSH = 1'b1;
        end
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("flush_busy_low", 32'(BUSY), 32'd0);
        chk("flush_done_low", 32'(DONE), 32'd0);
        chk("flush_result_kept", RESULT, lastRes);
        sawBusy = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge CLK);
            if (DONE === 1'b1) sawDone = 1'b1;
            if (BUSY === 1'b1) sawBusy = 1'b1;
        end
        chk("flush_no_done", 32'(sawDone), 32'd0);
        chk("flush_stays_idle", 32'(sawBusy), 32'd0);
        chk("flush_result_still_kept", RESULT, lastRes);
        runOp(OP_MUL, 32'd3, 32'd3, 32'd9, MUL_LAT, "mul_3_3");

        // FLUSH together with START in IDLE blocks acceptance.
        SELECT = OP_MUL;
        DATA1  = 32'd4;
        DATA2  = 32'd4;
        START  = 1'b1;
        FLUSH  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        FLUSH = 1'b0;
        chk("flush_start_not_accepted", 32'(BUSY), 32'd0);

        // Reset in the middle of a divide.
        sawDone = 1'b0;
        SELECT = OP_DIVU;
        DATA1  = 32'd1000;
        DATA2  = 32'd3;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge CLK);
            if (DONE === 1'b1) sawDone = 1'b1;
        end
        RESET = 1'b0;
        @(negedge CLK);
        chk("midreset_busy", 32'(BUSY), 32'd0);
        chk("midreset_done", 32'(DONE), 32'd0);
        chk("midreset_result", RESULT, 32'h0);
        RESET = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (DONE === 1'b1) sawDone = 1'b1;
        end
        chk("midreset_no_done", 32'(sawDone), 32'd0);

        // Non-M op code is ignored.
        sawBusy = 1'b0;
        SELECT = 5'b00000;
        DATA1  = 32'd1;
        DATA2  = 32'd2;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge CLK);
            if (BUSY === 1'b1) sawBusy = 1'b1;
        end
        chk("add_ignored_busy", 32'(sawBusy), 32'd0);
        chk("add_ignored_result", RESULT, 32'h0);

        runOp(OP_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT, "divu_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
